// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// One bit per cycle: a start pulse gives a result and exception flag WIDTH+1 edges later.
module multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] rem, rem_nxt, quo, quo_nxt, dvs, dvs_nxt;
  logic             neg, neg_nxt, dz, dz_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             exc_nxt, rdy_nxt, busy_nxt;

  logic [WIDTH:0]     booth_sum, div_shift, div_diff;
  logic [AW-1:0]      booth_acc;
  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;
  logic [WIDTH-1:0]   rem_step, quo_step, quo_signed, mag_a, mag_b;

  // One Booth step and one restoring-division step; sum kept WIDTH+1 wide so -2^(W-1) never overflows
  always_comb begin
    booth_sum = {acc[AW-1], acc[AW-1:WIDTH+1]};
    if (acc[1:0] == 2'b01) begin
      booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
    end else if (acc[1:0] == 2'b10) begin
      booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
    end
    booth_acc = {booth_sum, acc[WIDTH:1]};
    prod      = booth_acc[AW-1:1];
    mul_ovf   = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs};
    if (div_diff[WIDTH]) begin
      rem_step = div_shift[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = div_diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
    quo_signed = neg ? -quo_step : quo_step;

    mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  // Next-state and output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    rem_nxt    = rem;
    quo_nxt    = quo;
    dvs_nxt    = dvs;
    neg_nxt    = neg;
    dz_nxt     = dz;
    result_nxt = data_result;
    exc_nxt    = data_exception;
    rdy_nxt    = 1'b0;
    busy_nxt   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (ctrl_MULT) begin
          state_nxt = MUL;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          acc_nxt   = {{WIDTH{1'b0}}, data_operandB, 1'b0};
          mcand_nxt = data_operandA;
        end else if (ctrl_DIV) begin
          state_nxt = DIV;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          rem_nxt   = '0;
          quo_nxt   = mag_a;
          dvs_nxt   = mag_b;
          neg_nxt   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_nxt    = (data_operandB == '0);
        end
      end
      MUL: begin
        acc_nxt  = booth_acc;
        cnt_nxt  = cnt + CW'(1);
        busy_nxt = 1'b1;
        if (cnt == LAST) begin
          state_nxt  = DONE;
          cnt_nxt    = '0;
          busy_nxt   = 1'b0;
          rdy_nxt    = 1'b1;
          result_nxt = prod[WIDTH-1:0];
          exc_nxt    = mul_ovf;
        end
      end
      DIV: begin
        rem_nxt  = rem_step;
        quo_nxt  = quo_step;
        cnt_nxt  = cnt + CW'(1);
        busy_nxt = 1'b1;
        if (cnt == LAST) begin
          state_nxt  = DONE;
          cnt_nxt    = '0;
          busy_nxt   = 1'b0;
          rdy_nxt    = 1'b1;
          // Only a positive quotient of 2^(W-1) (min / -1) fails to fit
          result_nxt = dz ? '0 : quo_signed;
          exc_nxt    = dz | (!neg & quo_step[WIDTH-1]);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      acc            <= acc_nxt;
      mcand          <= mcand_nxt;
      rem            <= rem_nxt;
      quo            <= quo_nxt;
      dvs            <= dvs_nxt;
      neg            <= neg_nxt;
      dz             <= dz_nxt;
      data_result    <= result_nxt;
      data_exception <= exc_nxt;
      data_resultRDY <= rdy_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule
